// File: rtl/pyrm_branch_resolve_block_if.sv
// rtl/pyrm_branch_resolve_block_if.sv - fetch/execute/regfile handshake bundle for the branch resolve block
interface pyrm_branch_resolve_block_if #(
  parameter int XLEN   = 64,
  parameter int ILEN   = 32,
  parameter int REG_AW = 5
);
  logic [XLEN-1:0]   pc_pyri;
  logic              pc_valid_pyri;
  logic              pc_retry_pyro;
  logic [ILEN-1:0]   inst_pyri;
  logic              inst_valid_pyri;
  logic              inst_retry_pyro;
  logic [REG_AW-1:0] rs1_addr_pyro;
  logic [REG_AW-1:0] rs2_addr_pyro;
  logic [XLEN-1:0]   rs1_data_pyri;
  logic [XLEN-1:0]   rs2_data_pyri;
  logic              operands_ready_pyri;
  logic [XLEN-1:0]   branch_pc_pyro;
  logic              branch_pc_valid_pyro;
  logic              branch_pc_retry_pyri;
  logic [XLEN-1:0]   dec_pc_pyro;
  logic [ILEN-1:0]   dec_inst_pyro;
  logic              dec_valid_pyro;
  logic              dec_retry_pyri;

  // The resolve block itself
  modport slave (
    input  pc_pyri, pc_valid_pyri, inst_pyri, inst_valid_pyri,
    input  rs1_data_pyri, rs2_data_pyri, operands_ready_pyri,
    input  branch_pc_retry_pyri, dec_retry_pyri,
    output pc_retry_pyro, inst_retry_pyro, rs1_addr_pyro, rs2_addr_pyro,
    output branch_pc_pyro, branch_pc_valid_pyro,
    output dec_pc_pyro, dec_inst_pyro, dec_valid_pyro
  );

  // Surrounding fetch / execute / register file
  modport master (
    output pc_pyri, pc_valid_pyri, inst_pyri, inst_valid_pyri,
    output rs1_data_pyri, rs2_data_pyri, operands_ready_pyri,
    output branch_pc_retry_pyri, dec_retry_pyri,
    input  pc_retry_pyro, inst_retry_pyro, rs1_addr_pyro, rs2_addr_pyro,
    input  branch_pc_pyro, branch_pc_valid_pyro,
    input  dec_pc_pyro, dec_inst_pyro, dec_valid_pyro
  );
endinterface

// File: rtl/pyrm_branch_resolve_block.sv
// rtl/pyrm_branch_resolve_block.sv - one-entry fetch buffer forwarding to execute and resolving branch/jalr targets
module pyrm_branch_resolve_block #(
  parameter int XLEN   = 64,
  parameter int ILEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic clk,
  input  logic reset_n_pyri,
  pyrm_branch_resolve_block_if.slave bus
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic            ent_v;
  logic [XLEN-1:0] ent_pc;
  logic [ILEN-1:0] ent_inst;
  logic            fwd_done;
  logic            br_done;

  logic            is_jalr;
  logic            need_br;
  logic            dec_valid;
  logic            br_valid;
  logic            dec_xfer;
  logic            br_xfer;
  logic            in_xfer;
  logic            complete;
  logic            retry;
  logic            taken;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  // Handshake bookkeeping: the entry retires once both consumers it owes have taken it
  always_comb begin
    is_jalr   = (ent_inst[6:0] == OP_JALR);
    need_br   = (ent_inst[6:0] == OP_BRANCH) || is_jalr;
    dec_valid = ent_v && !fwd_done;
    br_valid  = ent_v && need_br && !br_done && bus.operands_ready_pyri;
    dec_xfer  = dec_valid && !bus.dec_retry_pyri;
    br_xfer   = br_valid && !bus.branch_pc_retry_pyri;
    complete  = ent_v && (fwd_done || dec_xfer) && (!need_br || br_done || br_xfer);
    retry     = ent_v && !complete;
    // Mismatched pc/inst valids are dropped rather than half-captured
    in_xfer   = bus.pc_valid_pyri && bus.inst_valid_pyri && !retry;
  end

  // Target resolution from the buffered instruction and same-cycle register data
  always_comb begin
    rs1      = bus.rs1_data_pyri;
    rs2      = bus.rs2_data_pyri;
    imm_i    = {{(XLEN-12){ent_inst[31]}}, ent_inst[31:20]};
    imm_b    = {{(XLEN-13){ent_inst[31]}}, ent_inst[31], ent_inst[7],
                ent_inst[30:25], ent_inst[11:8], 1'b0};
    jalr_sum = rs1 + imm_i;
    case (ent_inst[14:12])
      3'b000:  taken = (rs1 == rs2);
      3'b001:  taken = (rs1 != rs2);
      3'b100:  taken = ($signed(rs1) <  $signed(rs2));
      3'b101:  taken = ($signed(rs1) >= $signed(rs2));
      3'b110:  taken = (rs1 <  rs2);
      3'b111:  taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
    if (is_jalr) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (taken) begin
      target = ent_pc + imm_b;
    end else begin
      target = ent_pc + XLEN'(4);
    end
  end

  // Output drive: everything is zero whenever the entry is empty, including during reset
  always_comb begin
    bus.pc_retry_pyro        = retry;
    bus.inst_retry_pyro      = retry;
    bus.rs1_addr_pyro        = ent_v ? ent_inst[19:15] : '0;
    bus.rs2_addr_pyro        = ent_v ? ent_inst[24:20] : '0;
    bus.dec_valid_pyro       = dec_valid;
    bus.dec_pc_pyro          = ent_v ? ent_pc : '0;
    bus.dec_inst_pyro        = ent_v ? ent_inst : '0;
    bus.branch_pc_valid_pyro = br_valid;
    bus.branch_pc_pyro       = (ent_v && need_br) ? target : '0;
  end

  // Entry register: refill on capture (same cycle as retirement), drain, or record partial transfers
  always_ff @(posedge clk or negedge reset_n_pyri) begin
    if (!reset_n_pyri) begin
      ent_v    <= 1'b0;
      ent_pc   <= '0;
      ent_inst <= '0;
      fwd_done <= 1'b0;
      br_done  <= 1'b0;
    end else if (in_xfer) begin
      ent_v    <= 1'b1;
      ent_pc   <= bus.pc_pyri;
      ent_inst <= bus.inst_pyri;
      fwd_done <= 1'b0;
      br_done  <= 1'b0;
    end else if (complete) begin
      ent_v    <= 1'b0;
      fwd_done <= 1'b0;
      br_done  <= 1'b0;
    end else begin
      if (dec_xfer) fwd_done <= 1'b1;
      if (br_xfer)  br_done  <= 1'b1;
    end
  end
endmodule
